// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller: load-use bubbles, branch squash, memory freeze.
// Optional counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl #(
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs2,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rd,
   input  logic             ex_branch_taken,
   input  logic             mem_busy,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             id_ex_write,
   output logic             id_ex_bubble,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      FREEZE = 2'd1,
      FLUSH  = 2'd2,
      UNUSED = 2'd3
   } state_t;

   localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

   state_t     state, state_n;
   logic [2:0] flush_left, flush_left_n;
   logic       pending_br, pending_n;
   logic       lu, do_br, do_lu;
   logic       stall_inc, flush_inc;

   assign lu = ex_mem_read & (ex_rd != 5'd0) &
               ((ex_rd == id_rs1) |
                (id_uses_rs2 & (ex_rd == id_rs2)));

   assign state_o = state;

   // Next-state and pipeline control decode; memory freeze wins over all.
   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_write  = 1'b1;
      id_ex_bubble = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      state_n      = state;
      flush_left_n = flush_left;
      pending_n    = pending_br;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;
      do_br        = 1'b0;
      do_lu        = 1'b0;
      unique case (state)
         RUN: begin
            if (mem_busy) begin
               pc_write    = 1'b0;
               if_id_write = 1'b0;
               id_ex_write = 1'b0;
               pending_n   = ex_branch_taken;
               stall_inc   = 1'b1;
               state_n     = FREEZE;
            end else if (ex_branch_taken) begin
               do_br = 1'b1;
            end else if (lu) begin
               do_lu = 1'b1;
            end
         end
         FREEZE: begin
            if (mem_busy) begin
               pc_write    = 1'b0;
               if_id_write = 1'b0;
               id_ex_write = 1'b0;
               pending_n   = pending_br | ex_branch_taken;
               stall_inc   = 1'b1;
            end else begin
               state_n   = RUN;
               pending_n = 1'b0;
               if (pending_br | ex_branch_taken)
                  do_br = 1'b1;
               else if (lu)
                  do_lu = 1'b1;
            end
         end
         FLUSH: begin
            if (mem_busy) begin
               pc_write    = 1'b0;
               if_id_write = 1'b0;
               id_ex_write = 1'b0;
               stall_inc   = 1'b1;
            end else begin
               if_id_flush  = 1'b1;
               flush_left_n = flush_left - 3'd1;
               if (flush_left <= 3'd1)
                  state_n = RUN;
            end
         end
         default: begin
            state_n = RUN;
         end
      endcase
      if (do_br) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
         flush_inc   = 1'b1;
         if (FLUSH_CYCLES > 1) begin
            flush_left_n = FLUSH_INIT;
            state_n      = FLUSH;
         end else begin
            state_n = RUN;
         end
      end
      if (do_lu) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_bubble = 1'b1;
         stall_inc    = 1'b1;
      end
   end

   // State, remaining squash cycles and remembered branch.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= RUN;
         flush_left <= 3'd0;
         pending_br <= 1'b0;
      end else begin
         state      <= state_n;
         flush_left <= flush_left_n;
         pending_br <= pending_n;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_q, flush_q;

   // Saturating event counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (stall_inc && (stall_q != '1))
            stall_q <= stall_q + CNT_W'(1);
         if (flush_inc && (flush_q != '1))
            flush_q <= flush_q + CNT_W'(1);
      end
   end

   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;
`else
   logic unused_cnt_inc;
   assign unused_cnt_inc = stall_inc ^ flush_inc;
   assign stall_cnt      = '0;
   assign flush_cnt      = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl (FLUSH_CYCLES=3, CNT_W=4).
// Counter expectations follow HAZARD_PERF_CNT_EN.
module tb_hazard_stall_ctrl;

   localparam int CNT_W = 4;
`ifdef HAZARD_PERF_CNT_EN
   localparam bit EN = 1'b1;
`else
   localparam bit EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic [4:0]       id_rs1, id_rs2, ex_rd;
   logic             id_uses_rs2, ex_mem_read;
   logic             ex_branch_taken, mem_busy;
   logic             pc_write, if_id_write, id_ex_write;
   logic             id_ex_bubble, if_id_flush, id_ex_flush;
   logic [1:0]       state_o;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   int checks = 0;
   int errors = 0;

   hazard_stall_ctrl #(.FLUSH_CYCLES(3), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs2(id_uses_rs2),
      .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
      .ex_branch_taken(ex_branch_taken),
      .mem_busy(mem_busy),
      .pc_write(pc_write), .if_id_write(if_id_write),
      .id_ex_write(id_ex_write),
      .id_ex_bubble(id_ex_bubble),
      .if_id_flush(if_id_flush),
      .id_ex_flush(id_ex_flush),
      .state_o(state_o),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] cexp(input int v);
      return EN ? 32'(v) : 32'd0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
      id_uses_rs2 = 0; ex_mem_read = 0;
      ex_branch_taken = 0; mem_busy = 0;
   endtask

   task automatic chk_wr(input string tag,
                         input logic pc, ifw, idw);
      chk({tag, "_pc"}, 32'(pc_write), 32'(pc));
      chk({tag, "_ifw"}, 32'(if_id_write), 32'(ifw));
      chk({tag, "_idw"}, 32'(id_ex_write), 32'(idw));
   endtask

   initial begin
      idle();
      reset = 1;
      tick();
      tick();
      reset = 0;
      #1;
      // reset then idle
      chk_wr("idle", 1, 1, 1);
      chk("idle_bub", 32'(id_ex_bubble), 0);
      chk("idle_iff", 32'(if_id_flush), 0);
      chk("idle_ief", 32'(id_ex_flush), 0);
      chk("idle_st", 32'(state_o), 0);
      chk("idle_sc", 32'(stall_cnt), 0);
      chk("idle_fc", 32'(flush_cnt), 0);

      // load-use on rs1
      ex_mem_read = 1; ex_rd = 5; id_rs1 = 5;
      #1;
      chk_wr("lu1", 0, 0, 1);
      chk("lu1_bub", 32'(id_ex_bubble), 1);
      tick();
      chk("lu1_sc", 32'(stall_cnt), cexp(1));

      // x0 never hazards
      ex_rd = 0; id_rs1 = 0;
      #1;
      chk_wr("x0", 1, 1, 1);
      chk("x0_bub", 32'(id_ex_bubble), 0);
      tick();
      chk("x0_sc", 32'(stall_cnt), cexp(1));

      // rs2 match only counts when rs2 is used
      ex_rd = 7; id_rs1 = 3; id_rs2 = 7; id_uses_rs2 = 0;
      #1;
      chk("rs2n_pc", 32'(pc_write), 1);
      id_uses_rs2 = 1;
      #1;
      chk("rs2y_pc", 32'(pc_write), 0);
      chk("rs2y_bub", 32'(id_ex_bubble), 1);
      tick();
      chk("rs2y_sc", 32'(stall_cnt), cexp(2));

      // taken branch with coincident load-use
      idle();
      ex_branch_taken = 1; ex_mem_read = 1;
      ex_rd = 5; id_rs1 = 5;
      #1;
      chk("br0_iff", 32'(if_id_flush), 1);
      chk("br0_ief", 32'(id_ex_flush), 1);
      chk("br0_bub", 32'(id_ex_bubble), 0);
      chk("br0_pc", 32'(pc_write), 1);
      tick();
      idle();
      #1;
      chk("br1_st", 32'(state_o), 2);
      chk("br1_iff", 32'(if_id_flush), 1);
      chk("br1_ief", 32'(id_ex_flush), 0);
      chk("br1_fc", 32'(flush_cnt), cexp(1));
      tick();
      ex_mem_read = 1; ex_rd = 5; id_rs1 = 5;
      ex_branch_taken = 1;
      #1;
      chk("br2_st", 32'(state_o), 2);
      chk("br2_iff", 32'(if_id_flush), 1);
      chk("br2_pc", 32'(pc_write), 1);
      chk("br2_bub", 32'(id_ex_bubble), 0);
      tick();
      idle();
      #1;
      chk("br3_st", 32'(state_o), 0);
      chk("br3_iff", 32'(if_id_flush), 0);
      chk("br3_fc", 32'(flush_cnt), cexp(1));
      chk("br3_sc", 32'(stall_cnt), cexp(2));

      // memory freeze, branch during 2nd busy cycle
      for (int i = 0; i < 4; i++) begin
         mem_busy = 1;
         ex_branch_taken = (i == 1);
         #1;
         chk_wr("frz", 0, 0, 0);
         chk("frz_iff", 32'(if_id_flush), 0);
         tick();
      end
      idle();
      #1;
      chk("frz_st", 32'(state_o), 1);
      chk("frz_sc", 32'(stall_cnt), cexp(6));
      chk("frz_fc", 32'(flush_cnt), cexp(1));
      chk("rel_iff", 32'(if_id_flush), 1);
      chk("rel_ief", 32'(id_ex_flush), 1);
      chk("rel_pc", 32'(pc_write), 1);
      tick();
      chk("rel_fc", 32'(flush_cnt), cexp(2));
      chk("rel_st", 32'(state_o), 2);

      // reset in FLUSH with two cycles left
      reset = 1;
      tick();
      reset = 0;
      #1;
      chk("rst_st", 32'(state_o), 0);
      chk("rst_iff", 32'(if_id_flush), 0);
      chk("rst_sc", 32'(stall_cnt), 0);
      chk("rst_fc", 32'(flush_cnt), 0);

      // saturation of stall counter
      ex_mem_read = 1; ex_rd = 9; id_rs1 = 9;
      for (int i = 0; i < 15; i++) tick();
      chk("sat15_sc", 32'(stall_cnt), cexp(15));
      for (int i = 0; i < 5; i++) tick();
      chk("sat20_sc", 32'(stall_cnt), cexp(15));
      chk("sat_pc", 32'(pc_write), 0);

      // freeze inside FLUSH holds flush_left
      idle();
      ex_branch_taken = 1;
      tick();
      idle();
      mem_busy = 1;
      #1;
      chk("fh_st", 32'(state_o), 2);
      chk_wr("fh", 0, 0, 0);
      chk("fh_iff", 32'(if_id_flush), 0);
      tick();
      mem_busy = 0;
      #1;
      chk("fh1_st", 32'(state_o), 2);
      chk("fh1_iff", 32'(if_id_flush), 1);
      tick();
      chk("fh2_st", 32'(state_o), 2);
      chk("fh2_iff", 32'(if_id_flush), 1);
      tick();
      chk("fh3_st", 32'(state_o), 0);
      chk("fh3_fc", 32'(flush_cnt), cexp(1));

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
